// File: rtl/gate_pkg.sv
// -----------------------------------------------------------------------------
// gate_pkg
// Shared types and helpers for the mode-selectable wiring-logic gate.
//   gate_mode_e  : 3-bit function select encoding
//   gate_state_e : controller states (INIT / IDLE / HOLD)
//   exactly_one  : "exactly one bit set" test used by the XOR / XNOR modes
// Optional feature macro used by the gate: GATE_FAULTY_EN.
// -----------------------------------------------------------------------------
package gate_pkg;

   typedef enum logic [2:0] {
      MODE_AND    = 3'd0,
      MODE_OR     = 3'd1,
      MODE_XOR    = 3'd2,
      MODE_NAND   = 3'd3,
      MODE_NOR    = 3'd4,
      MODE_XNOR   = 3'd5,
      MODE_FAULTY = 3'd6,
      MODE_RSVD   = 3'd7
   } gate_mode_e;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_HOLD = 2'd2
   } gate_state_e;

   // Widest lamp bank the exactly_one helper handles; narrower banks are
   // zero-extended, which does not change the count of set bits.
   localparam int unsigned MAX_INPUTS = 32;

   // True when exactly one bit is set: non-zero and a power of two.
   function automatic logic exactly_one(input logic [MAX_INPUTS-1:0] v);
      return (v != '0) && ((v & (v - MAX_INPUTS'(1))) == '0);
   endfunction

endpackage

// File: rtl/gate_eval.sv
// -----------------------------------------------------------------------------
// gate_eval
// Purely combinational gate function: lamp inputs + mode -> eval.
// Ports:
//   in   [INPUT_COUNT-1:0]  lamp states
//   mode [2:0]              function select (gate_mode_e encoding)
//   eval                    selected function result
// FAULTY and reserved modes evaluate to 0; the faulty trigger behaviour lives
// in the controller.
// -----------------------------------------------------------------------------
module gate_eval
   import gate_pkg::*;
#(
   parameter int INPUT_COUNT = 2
) (
   input  logic [INPUT_COUNT-1:0] in,
   input  logic [2:0]             mode,
   output logic                   eval
);

   logic [MAX_INPUTS-1:0] in_ext;
   logic                  all_on;
   logic                  any_on;
   logic                  one_on;

   assign in_ext = MAX_INPUTS'(in);
   assign all_on = &in;
   assign any_on = |in;
   assign one_on = exactly_one(in_ext);

   always_comb begin
      eval = 1'b0;
      case (gate_mode_e'(mode))
         MODE_AND  : eval = all_on;
         MODE_OR   : eval = any_on;
         MODE_XOR  : eval = one_on;
         MODE_NAND : eval = ~all_on;
         MODE_NOR  : eval = ~any_on;
         MODE_XNOR : eval = ~one_on;
         default   : eval = 1'b0;
      endcase
   end

endmodule

// File: rtl/gate_multi_mode.sv
// -----------------------------------------------------------------------------
// gate_multi_mode
// Mode-selectable multi-input / multi-output gate with a registered level, a
// one-cycle change pulse and a post-change hold-off that filters chatter.
// Parameters:
//   INPUT_COUNT  number of lamp inputs
//   OUTPUT_COUNT number of replicated output wires
//   HOLD_CYCLES  hold-off length after a committed change (0 = none)
// Ports:
//   clk            clock, rising edge
//   logic_reset_n  asynchronous active-low reset
//   in             lamp states
//   mode           function select
//   trigger        faulty-mode trigger strobe
//   out_level      registered result, replicated
//   out_pulse      one-cycle strobe on each committed change / faulty fire
// Optional feature: define GATE_FAULTY_EN to enable the FAULTY mode (6) and
// the trigger input; otherwise mode 6 acts as the reserved mode.
// -----------------------------------------------------------------------------
module gate_multi_mode
   import gate_pkg::*;
#(
   parameter int INPUT_COUNT  = 2,
   parameter int OUTPUT_COUNT = 2,
   parameter int HOLD_CYCLES  = 0
) (
   input  logic                    clk,
   input  logic                    logic_reset_n,
   input  logic [INPUT_COUNT-1:0]  in,
   input  logic [2:0]              mode,
   input  logic                    trigger,
   output logic [OUTPUT_COUNT-1:0] out_level,
   output logic [OUTPUT_COUNT-1:0] out_pulse
);

   // A zero-length hold-off never enters HOLD; keep a 1-bit counter so the
   // register declaration stays legal.
   localparam int             CNT_W     = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
   localparam logic           USE_HOLD  = (HOLD_CYCLES > 0);
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);

   gate_state_e      state_reg,  state_next;
   logic             result_reg, result_next;
   logic             pulse_reg,  pulse_next;
   logic [CNT_W-1:0] cnt_reg,    cnt_next;

   logic eval;
   logic faulty_mode;
   logic faulty_fire;

   gate_eval #(
      .INPUT_COUNT (INPUT_COUNT)
   ) u_eval (
      .in   (in),
      .mode (mode),
      .eval (eval)
   );

`ifdef GATE_FAULTY_EN
   assign faulty_mode = (gate_mode_e'(mode) == MODE_FAULTY);
   assign faulty_fire = faulty_mode && trigger && (&in);
`else
   logic unused_trigger;
   assign unused_trigger = trigger;
   assign faulty_mode    = 1'b0;
   assign faulty_fire    = 1'b0;
`endif

   always_ff @(posedge clk or negedge logic_reset_n) begin
      if (!logic_reset_n) begin
         state_reg  <= ST_INIT;
         result_reg <= 1'b0;
         pulse_reg  <= 1'b0;
         cnt_reg    <= '0;
      end else begin
         state_reg  <= state_next;
         result_reg <= result_next;
         pulse_reg  <= pulse_next;
         cnt_reg    <= cnt_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      result_next = result_reg;
      pulse_next  = 1'b0;
      cnt_next    = cnt_reg;
      case (state_reg)
         // Silent load so inverting modes do not pulse out of reset.
         ST_INIT: begin
            result_next = eval;
            state_next  = ST_IDLE;
         end
         ST_IDLE: begin
            if (faulty_mode) begin
               // Level is pinned low; only the trigger produces a pulse.
               result_next = 1'b0;
               if (faulty_fire) begin
                  pulse_next = 1'b1;
                  if (USE_HOLD) begin
                     cnt_next   = HOLD_LOAD;
                     state_next = ST_HOLD;
                  end
               end
            end else if (eval != result_reg) begin
               result_next = eval;
               pulse_next  = 1'b1;
               if (USE_HOLD) begin
                  cnt_next   = HOLD_LOAD;
                  state_next = ST_HOLD;
               end
            end
         end
         // Inputs, mode and trigger are ignored here; IDLE re-evaluates
         // afresh, so only a net change across the window commits.
         ST_HOLD: begin
            cnt_next = cnt_reg - CNT_W'(1);
            if (cnt_reg == CNT_W'(1)) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_INIT;
         end
      endcase
   end

   generate
      for (genvar gi = 0; gi < OUTPUT_COUNT; gi++) begin : g_fanout
         assign out_level[gi] = result_reg;
         assign out_pulse[gi] = pulse_reg;
      end
   endgenerate

endmodule
